// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MULT/DIV unit with HI/LO registers and MTHI/MTLO writes.
// Define MIPS_MULDIV_DIV_EN to build the restoring divider (DIV/DIVU); otherwise those ops are ignored.
module mips_muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d, done_q, done_d;
   logic [31:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
   logic [63:0] acc_q, acc_d, prod, mul_step;
   logic [32:0] sum;
   logic [31:0] abs_a, abs_b;
   logic        a_neg, b_neg, go;
`ifdef MIPS_MULDIV_DIV_EN
   logic        is_div_q, is_div_d, sa_q, sa_d, dbz_q, dbz_d, ge;
   logic [32:0] shl;
   logic [31:0] rsub;
   localparam logic DIV_EN = 1'b1;
`else
   localparam logic DIV_EN = 1'b0;
`endif

   always_comb begin
      a_neg    = ~op[0] & operand_a[31];
      b_neg    = ~op[0] & operand_b[31];
      abs_a    = a_neg ? -operand_a : operand_a;
      abs_b    = b_neg ? -operand_b : operand_b;
      go       = start & ~op[2] & (DIV_EN | ~op[1]);
      // m_q holds the multiplicand or divisor; acc low half starts as multiplier or dividend
      sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
      mul_step = {sum, acc_q[31:1]};
      prod     = neg_q ? -acc_q : acc_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      m_d      = m_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      shl      = {acc_q[63:32], acc_q[31]};
      ge       = shl >= {1'b0, m_q};
      rsub     = shl[31:0] - m_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      dbz_d    = dbz_q;
`endif
      case (state_q)
         IDLE: begin
            if (start & op[2] & ~op[1]) begin
               hi_d = op[0] ? hi_q : operand_a;
               lo_d = op[0] ? operand_a : lo_q;
            end else if (go) begin
               state_d = CALC;
               cnt_d   = 6'd32;
               m_d     = op[1] ? abs_b : abs_a;
               acc_d   = {32'd0, op[1] ? abs_a : abs_b};
               neg_d   = a_neg ^ b_neg;
`ifdef MIPS_MULDIV_DIV_EN
               is_div_d = op[1];
               sa_d     = a_neg;
               dbz_d    = 1'b0;
`endif
            end
         end
         CALC: begin
            cnt_d   = cnt_q - 6'd1;
            state_d = (cnt_q == 6'd1) ? FIX : CALC;
`ifdef MIPS_MULDIV_DIV_EN
            acc_d   = is_div_q ? {ge ? rsub : shl[31:0], acc_q[30:0], ge} : mul_step;
`else
            acc_d   = mul_step;
`endif
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef MIPS_MULDIV_DIV_EN
            // a zero divisor leaves |dividend| as remainder, so the sign fix restores operand_a
            dbz_d = is_div_q & ~|m_q;
            hi_d  = is_div_q ? (sa_q ? -acc_q[63:32] : acc_q[63:32]) : prod[63:32];
            lo_d  = is_div_q ? (~|m_q ? 32'hFFFF_FFFF : neg_q ? -acc_q[31:0] : acc_q[31:0])
                             : prod[31:0];
`else
            hi_d  = prod[63:32];
            lo_d  = prod[31:0];
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         m_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

`ifdef MIPS_MULDIV_DIV_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         dbz_q    <= dbz_d;
      end
   end
   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

   assign busy = state_q != IDLE;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: table-driven vectors with a result scoreboard plus reset, MTHI/MTLO and busy corner cases.
module tb_mips_muldiv;
   logic        clk = 1'b0, reset, start;
   logic [2:0]  op;
   logic [31:0] a, b, hi, lo;
   logic        busy, done, dbz;

   always #5 clk = ~clk;

   mips_muldiv dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .operand_a(a), .operand_b(b),
      .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
   );

   typedef struct {logic [2:0] op; logic [31:0] a, b, hi, lo; logic dbz;} vec_t;
   typedef struct {logic [31:0] hi, lo; logic dbz;} exp_t;
   vec_t vecs[$];
   exp_t sb[$];
   int checks = 0, failures = 0;
   logic [31:0] cur_hi = '0, cur_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic add(input logic [2:0] o, input logic [31:0] x, y, eh, el, input logic ed);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.hi = eh; v.lo = el; v.dbz = ed;
      vecs.push_back(v);
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, y);
      exp_t e;
      longint sx, sy;
      logic [63:0] p, q, r;
      sx = o[0] ? longint'({32'd0, x}) : longint'($signed(x));
      sy = o[0] ? longint'({32'd0, y}) : longint'($signed(y));
      e.dbz = 1'b0;
      if (!o[1]) begin
         p = sx * sy;
         e.hi = p[63:32]; e.lo = p[31:0];
      end else if (y == 0) begin
         e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
      end else begin
         q = sx / sy; r = sx % sy;
         e.hi = r[31:0]; e.lo = q[31:0];
      end
      return e;
   endfunction

   task automatic issue(input vec_t v);
      exp_t e;
      e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz;
      sb.push_back(e);
      op = v.op; a = v.a; b = v.b; start = 1'b1;
   endtask

   task automatic wait_done(input string name, input bit intrude);
      int lat = 0;
      exp_t e;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk({name, " busy"}, busy, 1);
            chk({name, " stale_hi"}, hi, cur_hi);
            chk({name, " stale_lo"}, lo, cur_lo);
            start = 1'b0;
         end
         if (intrude && i == 5) begin
            start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd2;
         end
         if (intrude && i == 6) start = 1'b0;
         if (done) lat = i;
      end
      chk({name, " latency"}, lat, 34);
      e = sb.pop_front();
      chk({name, " hi"}, hi, e.hi);
      chk({name, " lo"}, lo, e.lo);
      chk({name, " dbz"}, dbz, e.dbz);
      chk({name, " busy_at_done"}, busy, 0);
      cur_hi = e.hi;
      cur_lo = e.lo;
   endtask

   initial begin
      exp_t e;
      vec_t v;
      int pulses;
      logic [2:0] ro;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset hi", hi, 0);
      chk("reset lo", lo, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset dbz", dbz, 0);

      add(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      add(3'b000, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      add(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      add(3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
      add(3'b001, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0);
`ifdef MIPS_MULDIV_DIV_EN
      add(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      add(3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
      add(3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
      add(3'b000, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0);
      add(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      add(3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
      add(3'b010, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      add(3'b011, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0);
`endif
      for (int k = 0; k < 4; k++) begin
`ifdef MIPS_MULDIV_DIV_EN
         ro = 3'($urandom_range(0, 3));
`else
         ro = 3'($urandom_range(0, 1));
`endif
         ra = $urandom; rb = $urandom;
         e = model(ro, ra, rb);
         add(ro, ra, rb, e.hi, e.lo, e.dbz);
      end

      // every vector is issued on the edge where the previous done is high
      foreach (vecs[k]) begin
         issue(vecs[k]);
         wait_done($sformatf("vec%0d", k), k == 1);
      end

      op = 3'b100; a = 32'h1234_5678; start = 1'b1;
      @(negedge clk);
      chk("mthi hi", hi, 32'h1234_5678);
      chk("mthi done", done, 0);
      chk("mthi busy", busy, 0);
      op = 3'b101; a = 32'h9ABC_DEF0;
      @(negedge clk);
      chk("mtlo lo", lo, 32'h9ABC_DEF0);
      chk("mtlo hi", hi, 32'h1234_5678);
      chk("mtlo done", done, 0);
      start = 1'b0;
      @(negedge clk);
      chk("mt after done", done, 0);
      cur_hi = 32'h1234_5678; cur_lo = 32'h9ABC_DEF0;

`ifndef MIPS_MULDIV_DIV_EN
      op = 3'b010; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("div ignored busy", busy, 0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("div ignored done", pulses, 0);
      chk("div ignored hi", hi, cur_hi);
      chk("div ignored lo", lo, cur_lo);
`endif

`ifdef MIPS_MULDIV_DIV_EN
      op = 3'b010;
`else
      op = 3'b000;
`endif
      a = 32'd1000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort busy", busy, 0);
      chk("abort hi", hi, 0);
      chk("abort lo", lo, 0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort done", pulses, 0);
      cur_hi = '0; cur_lo = '0;
      v.op = 3'b000; v.a = 32'd6; v.b = 32'hFFFF_FFF9; v.hi = 32'hFFFF_FFFF; v.lo = 32'hFFFF_FFD6; v.dbz = 1'b0;
      issue(v);
      wait_done("post_abort", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
